// File: rtl/irq_pkg.sv
// =============================================================================
// irq_pkg -- shared constants, types and helpers for the interrupt pending stage
// Revision: 1.0
// =============================================================================
`default_nettype none

package irq_pkg;

  localparam int N_IRQ = 8;
  localparam int VEC_W = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  typedef logic [VEC_W-1:0] irq_vec_t;
  typedef logic [N_IRQ-1:0] irq_mask_t;

  function automatic irq_mask_t vec2mask(input irq_vec_t v);
    irq_mask_t m;
    m    = '0;
    m[v] = 1'b1;
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_prio_sel.sv
// =============================================================================
// irq_prio_sel -- combinational highest-set-index selector with any-set flag
// Revision: 1.0
// =============================================================================
`default_nettype none

module irq_prio_sel
  import irq_pkg::*;
(
  input  logic [N_IRQ-1:0] i_req,
  output logic [VEC_W-1:0] o_idx,
  output logic             o_any_set
);

  // Ascending scan: the last hit, i.e. the highest index, wins.
  always_comb begin
    o_idx = '0;
    for (int k = 0; k < N_IRQ; k++) begin
      if (i_req[k]) begin
        o_idx = irq_vec_t'(k);
      end
    end
  end

  assign o_any_set = |i_req;

endmodule

`default_nettype wire

// File: rtl/irq_pend_ctrl.sv
// =============================================================================
// irq_pend_ctrl -- sync/edge-detect 8 request lines, latch pending, present the
// highest enabled request over valid/ack. IRQ_LEVEL_EN selects level mode.
// Revision: 1.0
// =============================================================================
`default_nettype none

module irq_pend_ctrl
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] mask,
  input  logic             irq_ack,
  output logic             irq_valid,
  output logic [VEC_W-1:0] irq_vec,
  output logic [N_IRQ-1:0] pend
);

  irq_mask_t r_sync1;
  irq_mask_t r_sync2;
  irq_mask_t r_pend;
  irq_mask_t w_set;
  irq_mask_t w_clr;
  irq_mask_t w_elig;
  irq_vec_t  w_sel;
  logic      w_any;
  state_t    r_state;
  logic      r_valid;
  irq_vec_t  r_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef IRQ_LEVEL_EN
  assign w_set = r_sync2;
`else
  irq_mask_t r_sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync2_q <= '0;
    end else begin
      r_sync2_q <= r_sync2;
    end
  end

  assign w_set = r_sync2 & ~r_sync2_q;
`endif

  assign w_clr  = ((r_state == PRESENT) && irq_ack) ? vec2mask(r_vec) : '0;
  assign w_elig = r_pend & mask;

  irq_prio_sel u_prio_sel (
    .i_req     (w_elig),
    .o_idx     (w_sel),
    .o_any_set (w_any)
  );

  // Set is OR-ed after the clear so a simultaneous new request survives its ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_vec   <= '0;
      r_pend  <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_vec   <= w_sel;
            r_valid <= 1'b1;
            r_state <= PRESENT;
          end
        end
        PRESENT: begin
          if (irq_ack) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign irq_valid = r_valid;
  assign irq_vec   = r_vec;
  assign pend      = r_pend;

endmodule

`default_nettype wire

// File: tb/tb_irq_pend_ctrl.sv
// =============================================================================
// tb_irq_pend_ctrl -- vector table, corner-case sequences and random run
// against a history-based reference model of the pending stage.
// Revision: 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_irq_pend_ctrl;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] irq_in  = 8'h00;
  logic [7:0] mask    = 8'hFF;
  logic       irq_ack = 1'b0;
  logic       irq_valid;
  logic [2:0] irq_vec;
  logic [7:0] pend;

  always #5 clk = ~clk;

  irq_pend_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .mask      (mask),
    .irq_ack   (irq_ack),
    .irq_valid (irq_valid),
    .irq_vec   (irq_vec),
    .pend      (pend)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending set from the sample history (high two samples
  // ago, low three samples ago), cleared by ack of the presented vector.
  logic [7:0] m_hist[$];
  logic [7:0] m_pend;
  bit         m_valid;
  int         m_vec;

  typedef struct {
    logic [7:0] in;
    logic [7:0] m;
    logic       ack;
    logic       ev;
    logic [2:0] evec;
    logic [7:0] ep;
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int highest(input logic [7:0] v);
    for (int k = 7; k >= 0; k--) begin
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_pend  = 8'h00;
    m_valid = 1'b0;
    m_vec   = 0;
  endtask

  task automatic model_edge(input logic [7:0] in, input logic [7:0] msk, input logic ack);
    logic [7:0] rise, clr, elig, s2, s3;
    m_hist.push_front(in);
    while (m_hist.size() > 4) void'(m_hist.pop_back());
    s2   = (m_hist.size() > 2) ? m_hist[2] : 8'h00;
    s3   = (m_hist.size() > 3) ? m_hist[3] : 8'h00;
    rise = s2 & ~s3;
    elig = m_pend & msk;
    clr  = (m_valid && ack) ? (8'h01 << m_vec) : 8'h00;
    m_pend = (m_pend & ~clr) | rise;
    if (!m_valid) begin
      if (elig != 8'h00) begin
        m_valid = 1'b1;
        m_vec   = highest(elig);
      end
    end else if (ack) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(irq_in, mask, irq_ack);
    #1;
    check("model_valid", {7'b0, irq_valid}, {7'b0, m_valid});
    if (m_valid) check("model_vec", {5'b0, irq_vec}, m_vec[7:0]);
    check("model_pend", pend, m_pend);
  endtask

  task automatic cyc(input logic [7:0] i, input logic [7:0] m, input logic a);
    irq_in  = i;
    mask    = m;
    irq_ack = a;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            in     mask   ack   valid vec   pend
    tbl[0]  = '{8'h10, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00};
    tbl[1]  = '{8'h10, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00};
    tbl[2]  = '{8'h00, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h10};
    tbl[3]  = '{8'h00, 8'hFF, 1'b0, 1'b1, 3'd4, 8'h10};
    tbl[4]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[5]  = '{8'h00, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00};
    tbl[6]  = '{8'h82, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00};
    tbl[7]  = '{8'h00, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00};
    tbl[8]  = '{8'h00, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h82};
    tbl[9]  = '{8'h00, 8'hFF, 1'b0, 1'b1, 3'd7, 8'h82};
    tbl[10] = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h02};
    tbl[11] = '{8'h00, 8'hFF, 1'b0, 1'b1, 3'd1, 8'h02};
    tbl[12] = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[13] = '{8'h00, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00};
    tbl[14] = '{8'h80, 8'h7F, 1'b0, 1'b0, 3'd0, 8'h00};
    tbl[15] = '{8'h00, 8'h7F, 1'b0, 1'b0, 3'd0, 8'h00};
    tbl[16] = '{8'h00, 8'h7F, 1'b0, 1'b0, 3'd0, 8'h80};
    tbl[17] = '{8'h00, 8'h7F, 1'b0, 1'b0, 3'd0, 8'h80};
    tbl[18] = '{8'h00, 8'h7F, 1'b1, 1'b0, 3'd0, 8'h80};
    tbl[19] = '{8'h00, 8'hFF, 1'b0, 1'b1, 3'd7, 8'h80};
    tbl[20] = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[21] = '{8'h00, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00};

    // Reset state
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {7'b0, irq_valid}, 8'h00);
    check("reset_vec", {5'b0, irq_vec}, 8'h00);
    check("reset_pend", pend, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: single edge, priority, mask
    for (int i = 0; i < 22; i++) begin
      cyc(tbl[i].in, tbl[i].m, tbl[i].ack);
      check($sformatf("tbl%0d_valid", i), {7'b0, irq_valid}, {7'b0, tbl[i].ev});
      if (tbl[i].ev) check($sformatf("tbl%0d_vec", i), {5'b0, irq_vec}, {5'b0, tbl[i].evec});
      check($sformatf("tbl%0d_pend", i), pend, tbl[i].ep);
    end

    // Hold without ack: a later higher request must not retract vector 2
    cyc(8'h04, 8'hFF, 1'b0);
    repeat (3) cyc(8'h00, 8'hFF, 1'b0);
    check("hold_valid", {7'b0, irq_valid}, 8'h01);
    check("hold_vec", {5'b0, irq_vec}, 8'h02);
    for (int i = 0; i < 10; i++) begin
      cyc(8'h40, 8'hFF, 1'b0);
      check($sformatf("hold%0d_vec", i), {5'b0, irq_vec}, 8'h02);
    end
    check("hold_pend", pend, 8'h44);
    cyc(8'h40, 8'hFF, 1'b1);
    check("hold_ack_valid", {7'b0, irq_valid}, 8'h00);
    check("hold_ack_pend", pend, 8'h40);
    cyc(8'h00, 8'hFF, 1'b0);
    check("hold_next_vec", {5'b0, irq_vec}, 8'h06);
    cyc(8'h00, 8'hFF, 1'b1);
    cyc(8'h00, 8'hFF, 1'b0);

    // Collision: new rise on bit 3 in the ack cycle of vector 3
    cyc(8'h08, 8'hFF, 1'b0);
    repeat (3) cyc(8'h00, 8'hFF, 1'b0);
    check("coll_vec", {5'b0, irq_vec}, 8'h03);
    cyc(8'h08, 8'hFF, 1'b0);
    cyc(8'h00, 8'hFF, 1'b0);
    cyc(8'h00, 8'hFF, 1'b1);
    check("coll_pend", pend, 8'h08);
    check("coll_valid", {7'b0, irq_valid}, 8'h00);
    cyc(8'h00, 8'hFF, 1'b0);
    check("coll_re_valid", {7'b0, irq_valid}, 8'h01);
    check("coll_re_vec", {5'b0, irq_vec}, 8'h03);
    cyc(8'h00, 8'hFF, 1'b1);
    check("coll_done_pend", pend, 8'h00);
    cyc(8'h00, 8'hFF, 1'b0);

    // Asynchronous reset during presentation
    cyc(8'h05, 8'hFF, 1'b0);
    repeat (3) cyc(8'h00, 8'hFF, 1'b0);
    check("rst_pre_pend", pend, 8'h05);
    check("rst_pre_vec", {5'b0, irq_vec}, 8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", {7'b0, irq_valid}, 8'h00);
    check("rst_async_vec", {5'b0, irq_vec}, 8'h00);
    check("rst_async_pend", pend, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(8'h00, 8'hFF, 1'b0);
      check($sformatf("rst_idle%0d_valid", i), {7'b0, irq_valid}, 8'h00);
    end

    // Line held high through reset release is one rising edge
    irq_in = 8'h01;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    repeat (3) cyc(8'h01, 8'hFF, 1'b0);
    check("held_pend", pend, 8'h01);
    cyc(8'h01, 8'hFF, 1'b0);
    check("held_vec_valid", {7'b0, irq_valid}, 8'h01);
    cyc(8'h01, 8'hFF, 1'b1);
    repeat (3) cyc(8'h01, 8'hFF, 1'b0);
    check("held_once_pend", pend, 8'h00);
    check("held_once_valid", {7'b0, irq_valid}, 8'h00);
    repeat (2) cyc(8'h00, 8'hFF, 1'b0);

    // Random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] nin, nm;
      nin = irq_in;
      nm  = mask;
      if ($urandom_range(0, 3) == 0) nin = nin ^ (8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 15) == 0) nm = 8'($urandom) | 8'($urandom);
      cyc(nin, nm, ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
